// File: rtl/pwl2bit_sync.sv
// Clocked hysteresis slicer: evaluates a PWL segment {offset, slope, t0} at each clk edge
// and debounces threshold crossings into a registered logic level with edge pulses.
module pwl2bit_sync #(
    parameter int val_w  = 24,      // signed fixed-point value width (default scale 2^16 per volt)
    parameter int time_w = 32,      // time base width, one LSB per clk period
    parameter int vth    = 32768,   // centre threshold, value LSBs
    parameter int vhys   = 6554,    // total hysteresis width, value LSBs
    parameter int ndeb   = 3,
    parameter bit init   = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*val_w+time_w-1:0] in,
    output logic                      out,
    output logic                      rise,
    output logic                      fall,
    output logic [15:0]               ncross
);

    localparam int ndeb_c = (ndeb < 1) ? 1 : ndeb;
    localparam int vhys_c = (vhys < 0) ? 0 : vhys;
    localparam int cnt_w  = $clog2(ndeb_c + 1);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(ndeb_c - 1);

    // Trip points are compared at twice the value scale so vhys/2 stays exact.
    localparam logic signed [63:0] thr_hi = 64'(2 * longint'(vth) + longint'(vhys_c));
    localparam logic signed [63:0] thr_lo = 64'(2 * longint'(vth) - longint'(vhys_c));

    typedef enum logic [1:0] {S_L, P_H, S_H, P_L} state_t;

    state_t              state_reg;
    logic [cnt_w-1:0]    count_reg;
    logic [time_w-1:0]   t_now_reg;
    logic                out_reg;
    logic                rise_reg;
    logic                fall_reg;
    logic [15:0]         ncross_reg;

    logic signed [val_w-1:0]  offset;
    logic signed [val_w-1:0]  slope;
    logic [time_w-1:0]        t0;
    logic signed [time_w-1:0] dt;
    logic signed [63:0]       v2;
    logic                     is_hi;
    logic                     is_lo;

    assign {offset, slope, t0} = in;
    // Modular difference keeps the evaluation correct across time base wrap.
    assign dt    = $signed(t_now_reg - t0);
    assign v2    = (64'(offset) + 64'(slope) * 64'(dt)) <<< 1;
    assign is_hi = (v2 > thr_hi);
    assign is_lo = (v2 < thr_lo);

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= init ? S_H : S_L;
            count_reg  <= '0;
            t_now_reg  <= '0;
            out_reg    <= init;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
            ncross_reg <= '0;
        end else begin
            t_now_reg <= t_now_reg + 1'b1;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            case (state_reg)
                S_L: begin
                    if (is_hi) begin
                        if (ndeb_c == 1) begin
                            state_reg  <= S_H;
                            out_reg    <= 1'b1;
                            rise_reg   <= 1'b1;
                            ncross_reg <= sat_inc(ncross_reg);
                        end else begin
                            state_reg <= P_H;
                            count_reg <= cnt_w'(1);
                        end
                    end
                end
                P_H: begin
                    if (!is_hi) begin
                        state_reg <= S_L;
                        count_reg <= '0;
                    end else if (count_reg == cnt_last) begin
                        state_reg  <= S_H;
                        count_reg  <= '0;
                        out_reg    <= 1'b1;
                        rise_reg   <= 1'b1;
                        ncross_reg <= sat_inc(ncross_reg);
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                S_H: begin
                    if (is_lo) begin
                        if (ndeb_c == 1) begin
                            state_reg  <= S_L;
                            out_reg    <= 1'b0;
                            fall_reg   <= 1'b1;
                            ncross_reg <= sat_inc(ncross_reg);
                        end else begin
                            state_reg <= P_L;
                            count_reg <= cnt_w'(1);
                        end
                    end
                end
                P_L: begin
                    if (!is_lo) begin
                        state_reg <= S_H;
                        count_reg <= '0;
                    end else if (count_reg == cnt_last) begin
                        state_reg  <= S_L;
                        count_reg  <= '0;
                        out_reg    <= 1'b0;
                        fall_reg   <= 1'b1;
                        ncross_reg <= sat_inc(ncross_reg);
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_L;
                    count_reg <= '0;
                end
            endcase
        end
    end

    assign out    = out_reg;
    assign rise   = rise_reg;
    assign fall   = fall_reg;
    assign ncross = ncross_reg;

endmodule
